// File: rtl/key_sw_io_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_map_pkg
//  Desc     : Shared I/O address map and register decode for the data bus.
//  Revision : 1.0  initial release
// ============================================================================
package io_map_pkg;

    localparam logic [15:0] IO_KDATA   = 16'hFFF0;
    localparam logic [15:0] IO_SDATA   = 16'hFFF2;
    localparam logic [15:0] IO_KCTRL   = 16'hFFF4;
    localparam logic [15:0] IO_KEVT    = 16'hFFF6;
    localparam logic [15:0] IO_LEDR    = 16'hFFF8;
    localparam logic [15:0] IO_LEDG    = 16'hFFFA;
    localparam logic [15:0] IO_HEX     = 16'hFFFC;
    localparam logic [15:0] IO_DEFAULT = 16'hDEAD;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_KDATA = 3'd1,
        SEL_SDATA = 3'd2,
        SEL_KCTRL = 3'd3,
        SEL_KEVT  = 3'd4
    } io_sel_e;

    typedef struct packed {
        logic       ovr;
        logic [3:0] evt;
    } kevt_t;

    function automatic io_sel_e io_decode(input logic [15:0] addr);
        io_sel_e sel;
        case (addr)
            IO_KDATA: sel = SEL_KDATA;
            IO_SDATA: sel = SEL_SDATA;
            IO_KCTRL: sel = SEL_KCTRL;
            IO_KEVT:  sel = SEL_KEVT;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sw_io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_sw_io_responder_if
//  Desc     : CPU data-memory read/write path towards the I/O responder.
//  Revision : 1.0  initial release
// ============================================================================
interface key_sw_io_responder_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] ADDR;
    logic             RE;
    logic             WE;
    logic [DBITS-1:0] DIN;
    logic             HIT;
    logic [DBITS-1:0] DOUT;

    modport master (output ADDR, RE, WE, DIN, input  HIT, DOUT);
    modport slave  (input  ADDR, RE, WE, DIN, output HIT, DOUT);
endinterface
`default_nettype wire

// File: rtl/key_sw_io_responder_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : io_debouncer
//  Desc     : 2-flop synchroniser plus tick-sampled history filter per bit.
//  Revision : 1.0  initial release
// ============================================================================
module io_debouncer #(
    parameter int               WIDTH    = 4,
    parameter int               DB_DEPTH = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             tick_i,
    input  wire logic [WIDTH-1:0] raw_i,
    output logic      [WIDTH-1:0] db_o,
    output logic      [WIDTH-1:0] rise_o,
    output logic      [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] hist_q [DB_DEPTH];
    logic [WIDTH-1:0] hist_d [DB_DEPTH];
    logic [WIDTH-1:0] all_hi;
    logic [WIDTH-1:0] all_lo;

    // The filter looks at the history including the sample taken this tick,
    // so the debounced bit moves on the same edge the last agreeing sample lands.
    always_comb begin
        for (int k = 0; k < DB_DEPTH; k++) begin
            hist_d[k] = hist_q[k];
        end
        db_d   = db_q;
        all_hi = '1;
        all_lo = '1;
        if (tick_i) begin
            hist_d[0] = sync2_q;
            for (int k = 1; k < DB_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            for (int k = 0; k < DB_DEPTH; k++) begin
                all_hi = all_hi & hist_d[k];
                all_lo = all_lo & ~hist_d[k];
            end
            db_d = (db_q | all_hi) & ~all_lo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            db_q    <= RST_VAL;
            for (int k = 0; k < DB_DEPTH; k++) begin
                hist_q[k] <= RST_VAL;
            end
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int k = 0; k < DB_DEPTH; k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = ~db_q & db_d;
    assign fall_o = db_q & ~db_d;

endmodule
`default_nettype wire

// File: rtl/key_sw_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : key_sw_io_responder
//  Desc     : Memory-mapped KEY/SW responder with debouncing and sticky events.
//  Revision : 1.0  initial release
// ============================================================================
module key_sw_io_responder
    import io_map_pkg::*;
#(
    parameter int DBITS    = 16,
    parameter int DB_TICK  = 50000,
    parameter int DB_DEPTH = 3
) (
    input  wire logic            CLK,
    input  wire logic            RESET_N,
    input  wire logic [3:0]      KEY,
    input  wire logic [9:0]      SW,
    key_sw_io_responder_if.slave bus
);

    localparam int PW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    logic [3:0]    key_db;
    logic [3:0]    key_rise;
    logic [3:0]    key_fall;
    logic [9:0]    sw_db;
    logic [9:0]    sw_rise_unused;
    logic [9:0]    sw_fall_unused;

    logic          kctrl_q;
    logic          kctrl_d;
    kevt_t         kevt_q;
    kevt_t         kevt_d;

    io_sel_e       sel;
    logic          upper_ok;
    logic [3:0]    qual;
    logic          clr;
    logic          din_unused;

    // Shared debounce prescaler
    always_comb begin
        tick    = (presc_q == PW'(DB_TICK - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    io_debouncer #(
        .WIDTH    (4),
        .DB_DEPTH (DB_DEPTH),
        .RST_VAL  (4'hF)
    ) u_key_db (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .tick_i (tick),
        .raw_i  (KEY),
        .db_o   (key_db),
        .rise_o (key_rise),
        .fall_o (key_fall)
    );

    io_debouncer #(
        .WIDTH    (10),
        .DB_DEPTH (DB_DEPTH),
        .RST_VAL  (10'h000)
    ) u_sw_db (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .tick_i (tick),
        .raw_i  (SW),
        .db_o   (sw_db),
        .rise_o (sw_rise_unused),
        .fall_o (sw_fall_unused)
    );

    // Wider buses must carry zeros above bit 15 to hit the map.
    generate
        if (DBITS > 16) begin : g_wide_addr
            assign upper_ok = ~|bus.ADDR[DBITS-1:16];
        end else begin : g_narrow_addr
            assign upper_ok = 1'b1;
        end
    endgenerate

    assign din_unused = ^bus.DIN[DBITS-1:1];

    always_comb begin
        sel = upper_ok ? io_decode(16'(bus.ADDR)) : SEL_NONE;
    end

    // A fresh edge overrides a same-cycle clear; OVR only accumulates otherwise.
    always_comb begin
        qual    = key_fall | (key_rise & {4{kctrl_q}});
        clr     = bus.RE && (sel == SEL_KEVT);
        kctrl_d = kctrl_q;
        if (bus.WE && (sel == SEL_KCTRL)) begin
            kctrl_d = bus.DIN[0];
        end
        kevt_d.evt = (clr ? 4'h0 : kevt_q.evt) | qual;
        kevt_d.ovr = clr ? 1'b0 : (kevt_q.ovr | (|(qual & kevt_q.evt)));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kctrl_q <= 1'b0;
            kevt_q  <= '0;
        end else begin
            kctrl_q <= kctrl_d;
            kevt_q  <= kevt_d;
        end
    end

    always_comb begin
        bus.HIT = (sel != SEL_NONE);
        case (sel)
            SEL_KDATA: bus.DOUT = DBITS'(key_db);
            SEL_SDATA: bus.DOUT = DBITS'(sw_db);
            SEL_KCTRL: bus.DOUT = DBITS'(kctrl_q);
            SEL_KEVT:  bus.DOUT = DBITS'(kevt_q);
            default:   bus.DOUT = DBITS'(IO_DEFAULT);
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_key_sw_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sw_io_responder
//  Desc     : Directed scoreboard bench for the KEY/SW I/O responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_sw_io_responder;
    import io_map_pkg::*;

    localparam int DBITS    = 16;
    localparam int DB_TICK  = 4;
    localparam int DB_DEPTH = 3;

    logic       CLK     = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] KEY     = 4'hF;
    logic [9:0] SW      = 10'h000;

    key_sw_io_responder_if #(.DBITS(DBITS)) bus ();

    key_sw_io_responder #(
        .DBITS    (DBITS),
        .DB_TICK  (DB_TICK),
        .DB_DEPTH (DB_DEPTH)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .KEY     (KEY),
        .SW      (SW),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    string       tag_q [$];
    logic [15:0] exp_q [$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic void sb_push(input string t, input logic [15:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endfunction

    task automatic sb_check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    // Read at the given address; RE makes it a consuming read.
    task automatic rd(input logic [15:0] a, input logic re, input logic [15:0] e, input string t);
        @(negedge CLK);
        bus.ADDR = a;
        bus.RE   = re;
        sb_push(t, e);
        #1 sb_check(bus.DOUT);
        @(posedge CLK);
        #1;
        bus.RE   = 1'b0;
        bus.ADDR = 16'h0100;
    endtask

    task automatic hit_chk(input logic [15:0] a, input logic e, input string t);
        @(negedge CLK);
        bus.ADDR = a;
        sb_push(t, {15'h0, e});
        #1 sb_check({15'h0, bus.HIT});
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        bus.ADDR = a;
        bus.DIN  = d;
        bus.WE   = 1'b1;
        @(posedge CLK);
        #1;
        bus.WE   = 1'b0;
        bus.ADDR = 16'h0100;
    endtask

    task automatic peek_now(input logic [15:0] a, input logic [15:0] e, input string t);
        bus.ADDR = a;
        #1;
        sb_push(t, e);
        sb_check(bus.DOUT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        stable;
        logic [15:0] pre;
        logic [15:0] post;

        bus.ADDR = 16'h0100;
        bus.RE   = 1'b0;
        bus.WE   = 1'b0;
        bus.DIN  = 16'h0000;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (40) @(negedge CLK);

        // 1. Idle state after reset
        rd(IO_KDATA, 1'b0, 16'h000F, "reset_kdata");
        rd(IO_SDATA, 1'b0, 16'h0000, "reset_sdata");
        rd(IO_KEVT,  1'b0, 16'h0000, "reset_kevt");
        rd(IO_KCTRL, 1'b0, 16'h0000, "reset_kctrl");
        hit_chk(16'h0100, 1'b0, "hit_0100");
        rd(16'h0100, 1'b0, 16'hDEAD, "dout_0100");
        hit_chk(16'hFFF1, 1'b0, "hit_odd_fff1");
        rd(16'hFFF1, 1'b0, 16'hDEAD, "dout_odd_fff1");
        hit_chk(IO_KEVT, 1'b1, "hit_kevt");
        hit_chk(16'hFFF8, 1'b0, "hit_ledr");

        // 2. Switch pattern through the filter, latency window
        @(negedge CLK);
        SW       = 10'h2A5;
        bus.ADDR = IO_SDATA;
        n        = 0;
        while (n < 30) begin
            @(posedge CLK);
            n++;
            #1;
            if (bus.DOUT == 16'h02A5) break;
        end
        sb_push("sw_latency_window", 16'h0001);
        sb_check({15'h0, (n >= 9 && n <= 18)});
        sb_push("sdata_2a5", 16'h02A5);
        sb_check(bus.DOUT);
        rd(IO_KEVT, 1'b1, 16'h0000, "kevt_after_sw");

        // 3. Bouncing KEY[1] press, glitch high one cycle in three
        @(negedge CLK);
        bus.ADDR = IO_KDATA;
        stable   = 1'b1;
        for (int c = 0; c < 30; c++) begin
            KEY[1] = (c % 3 == 2);
            @(negedge CLK);
            if (bus.DOUT !== 16'h000F) stable = 1'b0;
        end
        sb_push("kdata_stable_while_bouncing", 16'h0001);
        sb_check({15'h0, stable});
        KEY[1] = 1'b0;
        n = 0;
        while (n < 30 && bus.DOUT !== 16'h000D) begin
            @(negedge CLK);
            n++;
        end
        sb_push("kdata_key1_pressed", 16'h000D);
        sb_check(bus.DOUT);
        rd(IO_KEVT, 1'b1, 16'h0002, "kevt_key1");
        rd(IO_KEVT, 1'b1, 16'h0000, "kevt_key1_cleared");
        KEY[1] = 1'b1;
        repeat (24) @(negedge CLK);

        // 4. Two KEY[0] presses without a read -> overrun
        KEY[0] = 1'b0;
        repeat (24) @(negedge CLK);
        rd(IO_KDATA, 1'b0, 16'h000E, "kdata_key0_pressed");
        KEY[0] = 1'b1;
        repeat (24) @(negedge CLK);
        KEY[0] = 1'b0;
        repeat (24) @(negedge CLK);
        rd(IO_KEVT, 1'b1, 16'h0011, "kevt_overrun");
        rd(IO_KEVT, 1'b1, 16'h0000, "kevt_overrun_cleared");
        KEY[0] = 1'b1;
        repeat (24) @(negedge CLK);
        rd(IO_KEVT, 1'b0, 16'h0000, "kevt_release_ignored");

        // 5. Both-edge mode on KEY[2]; writes to read-only registers ignored
        wr(IO_KCTRL, 16'hFFFF);
        rd(IO_KCTRL, 1'b0, 16'h0001, "kctrl_readback");
        wr(IO_KDATA, 16'h0000);
        wr(IO_KEVT,  16'h001F);
        rd(IO_KEVT,  1'b0, 16'h0000, "kevt_write_ignored");
        KEY[2] = 1'b0;
        repeat (24) @(negedge CLK);
        rd(IO_KEVT, 1'b1, 16'h0004, "kevt_key2_press");
        KEY[2] = 1'b1;
        repeat (24) @(negedge CLK);
        rd(IO_KEVT, 1'b1, 16'h0004, "kevt_key2_release");
        rd(IO_KDATA, 1'b0, 16'h000F, "kdata_write_ignored");
        wr(IO_KCTRL, 16'h0000);
        rd(IO_KCTRL, 1'b0, 16'h0000, "kctrl_cleared");

        // 6. KEY[3] press landing in a KEVT read cycle
        @(negedge CLK);
        KEY[3]   = 1'b0;
        bus.ADDR = IO_KEVT;
        bus.RE   = 1'b1;
        pre      = 16'hFFFF;
        post     = 16'h0000;
        n        = 0;
        while (n < 40) begin
            @(negedge CLK);
            pre = bus.DOUT;
            @(posedge CLK);
            #1;
            post = bus.DOUT;
            n++;
            if (post != 16'h0000) break;
        end
        bus.RE = 1'b0;
        sb_push("kevt_dout_clear_cycle", 16'h0000);
        sb_check(pre);
        sb_push("kevt_edge_beats_clear", 16'h0008);
        sb_check(post);
        rd(IO_KDATA, 1'b0, 16'h0007, "kdata_key3_pressed");
        rd(IO_KEVT,  1'b1, 16'h0008, "kevt_key3_no_ovr");
        rd(IO_KEVT,  1'b1, 16'h0000, "kevt_key3_cleared");

        // Reset pulse while KEY[0] is mid-debounce
        wr(IO_KCTRL, 16'h0001);
        KEY[3] = 1'b1;
        repeat (24) @(negedge CLK);
        KEY[0] = 1'b0;
        repeat (6) @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        KEY     = 4'hF;
        SW      = 10'h000;
        peek_now(IO_KDATA, 16'h000F, "inreset_kdata");
        peek_now(IO_SDATA, 16'h0000, "inreset_sdata");
        peek_now(IO_KCTRL, 16'h0000, "inreset_kctrl");
        peek_now(IO_KEVT,  16'h0000, "inreset_kevt");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        rd(IO_KEVT,  1'b0, 16'h0000, "post_reset_kevt");
        rd(IO_KDATA, 1'b0, 16'h000F, "post_reset_kdata");
        rd(IO_SDATA, 1'b0, 16'h0000, "post_reset_sdata");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
